// File: rtl/trig_buffer_pkg.sv
// Shared widths and types for the trigger buffer allocator.
package trig_buffer_pkg;

    localparam int MAX_NBUF = 16;

    // $clog2 that never returns 0, so single-bit indices stay legal.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDX_W = clog2_safe(MAX_NBUF);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } buf_evt_t;

endpackage

// File: rtl/trig_buffer_alloc_if.sv
// Control inputs and status/event outputs of the trigger buffer allocator.
interface trig_buffer_alloc_if
    import trig_buffer_pkg::*;
#(
    parameter int NBUF      = 4,
    parameter int OCC_WIDTH = 32
);
    localparam int BUFBITS = clog2_safe(NBUF);
    localparam int CNTBITS = clog2_safe(NBUF + 1);

    logic                 pps_i;
    logic                 runrst_i;
    logic                 runstop_i;
    logic                 trig_i;
    logic                 last_flag_i;
    logic                 panic_i;
    logic                 trig_valid_o;
    logic [BUFBITS-1:0]   trig_buf_o;
    logic                 release_valid_o;
    logic [BUFBITS-1:0]   release_buf_o;
    logic [NBUF-1:0]      held_o;
    logic [CNTBITS-1:0]   held_count_o;
    logic                 dead_o;
    logic [OCC_WIDTH-1:0] occupancy_o;
    logic                 occupancy_valid_o;
    logic                 surf_err_o;
    logic                 turf_err_o;

    modport master (
        output pps_i, runrst_i, runstop_i, trig_i, last_flag_i, panic_i,
        input  trig_valid_o, trig_buf_o, release_valid_o, release_buf_o,
               held_o, held_count_o, dead_o, occupancy_o, occupancy_valid_o,
               surf_err_o, turf_err_o
    );

    modport slave (
        input  pps_i, runrst_i, runstop_i, trig_i, last_flag_i, panic_i,
        output trig_valid_o, trig_buf_o, release_valid_o, release_buf_o,
               held_o, held_count_o, dead_o, occupancy_o, occupancy_valid_o,
               surf_err_o, turf_err_o
    );

endinterface

// File: rtl/buf_ring_ptr.sv
// Modulo-N ring pointer: synchronous clear wins over increment, wraps N-1 -> 0.
module buf_ring_ptr #(
    parameter int N = 4,
    parameter int W = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/trig_buffer_alloc.sv
// Round-robin SURF buffer allocation on trigger, in-order release on event complete,
// with deadtime, sticky error flags and a per-PPS occupancy integral. 1-cycle registered outputs.
module trig_buffer_alloc
    import trig_buffer_pkg::*;
#(
    parameter int NBUF        = 4,
    parameter int DEAD_THRESH = NBUF,
    parameter int OCC_WIDTH   = 32
) (
    input logic                sys_clk_i,
    input logic                sys_rst_i,
    trig_buffer_alloc_if.slave bus
);

    localparam int BUFBITS = clog2_safe(NBUF);
    localparam int CNTBITS = clog2_safe(NBUF + 1);

    logic                 running;
    logic [CNTBITS-1:0]   count;
    logic [NBUF-1:0]      held;
    logic [BUFBITS-1:0]   wr_ptr;
    logic [BUFBITS-1:0]   rd_ptr;
    logic [OCC_WIDTH-1:0] acc;
    logic [OCC_WIDTH-1:0] occ;
    logic                 occ_valid;
    logic                 trig_valid;
    logic [BUFBITS-1:0]   trig_buf;
    logic                 rel_valid;
    logic [BUFBITS-1:0]   rel_buf;
    logic                 dead;
    logic                 surf_err;
    logic                 turf_err;

    logic                 full;
    logic                 empty;
    logic                 do_alloc;
    logic                 do_rel;
    logic                 run_next;
    logic [CNTBITS-1:0]   next_count;
    logic [NBUF-1:0]      next_held;
    logic [OCC_WIDTH:0]   acc_wide;
    logic [OCC_WIDTH-1:0] acc_sat;

    buf_ring_ptr #(.N(NBUF), .W(BUFBITS)) u_wr_ptr (
        .clk (sys_clk_i),
        .rst (sys_rst_i),
        .clr (bus.runrst_i),
        .inc (do_alloc),
        .ptr (wr_ptr)
    );

    buf_ring_ptr #(.N(NBUF), .W(BUFBITS)) u_rd_ptr (
        .clk (sys_clk_i),
        .rst (sys_rst_i),
        .clr (bus.runrst_i),
        .inc (do_rel),
        .ptr (rd_ptr)
    );

    // Allocation and release are judged independently against the pre-cycle count.
    always_comb begin
        full       = (count == CNTBITS'(NBUF));
        empty      = (count == '0);
        do_alloc   = bus.trig_i && !full && !bus.runrst_i;
        do_rel     = bus.last_flag_i && !empty && !bus.runrst_i;
        run_next   = bus.runrst_i ? 1'b1 : (bus.runstop_i ? 1'b0 : running);
        next_count = count;
        next_held  = held;
        if (do_alloc) begin
            next_count          = next_count + 1'b1;
            next_held[wr_ptr]   = 1'b1;
        end
        if (do_rel) begin
            next_count          = next_count - 1'b1;
            next_held[rd_ptr]   = 1'b0;
        end
        if (bus.runrst_i) begin
            next_count = '0;
            next_held  = '0;
        end
        acc_wide = {1'b0, acc} + {{(OCC_WIDTH + 1 - CNTBITS){1'b0}}, count};
        acc_sat  = acc_wide[OCC_WIDTH] ? '1 : acc_wide[OCC_WIDTH-1:0];
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            running    <= 1'b0;
            count      <= '0;
            held       <= '0;
            acc        <= '0;
            occ        <= '0;
            occ_valid  <= 1'b0;
            trig_valid <= 1'b0;
            trig_buf   <= '0;
            rel_valid  <= 1'b0;
            rel_buf    <= '0;
            dead       <= 1'b0;
            surf_err   <= 1'b0;
            turf_err   <= 1'b0;
        end else begin
            running    <= run_next;
            count      <= next_count;
            held       <= next_held;
            trig_valid <= do_alloc;
            trig_buf   <= wr_ptr;
            rel_valid  <= do_rel;
            rel_buf    <= rd_ptr;
            dead       <= run_next && ((next_count >= CNTBITS'(DEAD_THRESH)) || bus.panic_i);
            // PPS captures the integral before a coincident run reset clears it.
            occ_valid  <= bus.pps_i;
            if (bus.pps_i) begin
                occ <= acc_sat;
            end
            acc <= (bus.pps_i || bus.runrst_i) ? '0 : acc_sat;
            if (bus.runrst_i) begin
                surf_err <= 1'b0;
                turf_err <= 1'b0;
            end else begin
                if (bus.trig_i && full && running) begin
                    turf_err <= 1'b1;
                end
                if (bus.last_flag_i && empty && running) begin
                    surf_err <= 1'b1;
                end
            end
        end
    end

    assign bus.trig_valid_o      = trig_valid;
    assign bus.trig_buf_o        = trig_buf;
    assign bus.release_valid_o   = rel_valid;
    assign bus.release_buf_o     = rel_buf;
    assign bus.held_o            = held;
    assign bus.held_count_o      = count;
    assign bus.dead_o            = dead;
    assign bus.occupancy_o       = occ;
    assign bus.occupancy_valid_o = occ_valid;
    assign bus.surf_err_o        = surf_err;
    assign bus.turf_err_o        = turf_err;

endmodule

// File: tb/tb_trig_buffer_alloc.sv
// Two allocator instances (NBUF=4/OCC 32 and NBUF=3/OCC 8) driven by shared stimulus, scoreboarded against a FIFO model.
module tb_trig_buffer_alloc;
    import trig_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trig_buffer_alloc_if #(.NBUF(4), .OCC_WIDTH(32)) if0 ();
    trig_buffer_alloc_if #(.NBUF(3), .OCC_WIDTH(8))  if1 ();

    trig_buffer_alloc #(.NBUF(4), .DEAD_THRESH(4), .OCC_WIDTH(32)) u0 (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .bus       (if0)
    );

    trig_buffer_alloc #(.NBUF(3), .DEAD_THRESH(2), .OCC_WIDTH(8)) u1 (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .bus       (if1)
    );

    typedef struct {
        bit tv, rv, ov, dead, se, te;
        int held, cnt;
    } snap_t;

    int     checks = 0;
    int     errors = 0;

    int     nb [2] = '{4, 3};
    int     dt [2] = '{4, 2};
    longint mx [2] = '{64'hFFFF_FFFF, 64'hFF};

    int       hq [2][$];
    buf_evt_t tq [2][$];
    buf_evt_t rq [2][$];
    longint   oq [2][$];
    snap_t    sq [2][$];
    int       wp [2];
    longint   acc[2];
    bit       se [2];
    bit       te [2];
    bit       m_run;

    task automatic chk(input string nm, input longint a, input longint e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hq[i].delete();
            wp[i]  = 0;
            acc[i] = 0;
            se[i]  = 0;
            te[i]  = 0;
        end
        m_run = 0;
    endtask

    // One cycle of the reference: held buffers are a FIFO of indices, allocation walks wp modulo NBUF.
    task automatic step(input int i, input bit t, input bit l, input bit p, input bit rr,
                        input bit pn, input bit rn, output snap_t s);
        int     pre;
        longint sum;
        buf_evt_t ev;
        s   = '{default: 0};
        pre = hq[i].size();
        sum = acc[i] + pre;
        if (sum > mx[i]) sum = mx[i];
        if (p) begin
            oq[i].push_back(sum);
            s.ov   = 1;
            acc[i] = 0;
        end else begin
            acc[i] = sum;
        end
        if (rr) begin
            hq[i].delete();
            wp[i]  = 0;
            se[i]  = 0;
            te[i]  = 0;
            acc[i] = 0;
        end else begin
            if (t) begin
                if (pre < nb[i]) begin
                    hq[i].push_back(wp[i]);
                    ev.valid = 1'b1;
                    ev.idx   = IDX_W'(wp[i]);
                    tq[i].push_back(ev);
                    s.tv  = 1;
                    wp[i] = (wp[i] + 1) % nb[i];
                end else if (m_run) begin
                    te[i] = 1;
                end
            end
            if (l) begin
                if (pre > 0) begin
                    ev.valid = 1'b1;
                    ev.idx   = IDX_W'(hq[i].pop_front());
                    rq[i].push_back(ev);
                    s.rv = 1;
                end else if (m_run) begin
                    se[i] = 1;
                end
            end
        end
        for (int k = 0; k < hq[i].size(); k++) s.held |= (1 << hq[i][k]);
        s.cnt  = hq[i].size();
        s.dead = rn && ((s.cnt >= dt[i]) || pn);
        s.se   = se[i];
        s.te   = te[i];
    endtask

    task automatic drive(input bit t, input bit l, input bit p, input bit rr, input bit rs, input bit pn);
        if0.trig_i = t;  if0.last_flag_i = l; if0.pps_i = p;
        if0.runrst_i = rr; if0.runstop_i = rs; if0.panic_i = pn;
        if1.trig_i = t;  if1.last_flag_i = l; if1.pps_i = p;
        if1.runrst_i = rr; if1.runstop_i = rs; if1.panic_i = pn;
    endtask

    task automatic cyc(input bit t, input bit l, input bit p = 0, input bit rr = 0,
                       input bit rs = 0, input bit pn = 0);
        snap_t s0, s1;
        bit    rn;
        drive(t, l, p, rr, rs, pn);
        rn = rr ? 1'b1 : (rs ? 1'b0 : m_run);
        step(0, t, l, p, rr, pn, rn, s0);
        step(1, t, l, p, rr, pn, rn, s1);
        m_run = rn;
        @(posedge clk);
        sq[0].push_back(s0);
        sq[1].push_back(s1);
        #1;
    endtask

    task automatic do_reset(input int n);
        snap_t z;
        z   = '{default: 0};
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (n) begin
            @(posedge clk);
            sq[0].push_back(z);
            sq[1].push_back(z);
        end
        #1 rst = 1'b0;
    endtask

    task automatic mon(input int i, input bit tv, input int tb, input bit rv, input int rb,
                       input int held, input int cnt, input bit dead, input bit ov,
                       input longint occ, input bit se_a, input bit te_a);
        snap_t    s;
        buf_evt_t ev;
        if (sq[i].size() > 0) begin
            s = sq[i].pop_front();
            chk($sformatf("u%0d_held", i), held, s.held);
            chk($sformatf("u%0d_count", i), cnt, s.cnt);
            chk($sformatf("u%0d_dead", i), dead, s.dead);
            chk($sformatf("u%0d_trig_valid", i), tv, s.tv);
            chk($sformatf("u%0d_release_valid", i), rv, s.rv);
            chk($sformatf("u%0d_occ_valid", i), ov, s.ov);
            chk($sformatf("u%0d_surf_err", i), se_a, s.se);
            chk($sformatf("u%0d_turf_err", i), te_a, s.te);
        end
        if (tv) begin
            if (tq[i].size() == 0) chk($sformatf("u%0d_trig_unexpected", i), 1, 0);
            else begin
                ev = tq[i].pop_front();
                chk($sformatf("u%0d_trig_buf", i), tb, int'(ev.idx));
            end
        end
        if (rv) begin
            if (rq[i].size() == 0) chk($sformatf("u%0d_release_unexpected", i), 1, 0);
            else begin
                ev = rq[i].pop_front();
                chk($sformatf("u%0d_release_buf", i), rb, int'(ev.idx));
            end
        end
        if (ov) begin
            if (oq[i].size() == 0) chk($sformatf("u%0d_occ_unexpected", i), 1, 0);
            else chk($sformatf("u%0d_occupancy", i), occ, oq[i].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.trig_valid_o, int'(if0.trig_buf_o), if0.release_valid_o, int'(if0.release_buf_o),
            int'(if0.held_o), int'(if0.held_count_o), if0.dead_o, if0.occupancy_valid_o,
            longint'(if0.occupancy_o), if0.surf_err_o, if0.turf_err_o);
        mon(1, if1.trig_valid_o, int'(if1.trig_buf_o), if1.release_valid_o, int'(if1.release_buf_o),
            int'(if1.held_o), int'(if1.held_count_o), if1.dead_o, if1.occupancy_valid_o,
            longint'(if1.occupancy_o), if1.surf_err_o, if1.turf_err_o);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        do_reset(3);

        // Fill to full, overflow trigger, then run reset clears everything.
        cyc(0, 0, 0, 1);
        repeat (5) cyc(1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0);

        // Trigger/release pairs exercise pointer wrap and in-order release.
        repeat (7) begin
            cyc(1, 0);
            cyc(0, 1);
        end

        // Simultaneous trigger and release at count 2, then at count 0 and at full.
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 1);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 1);

        // Occupancy integral: hold count 2 across exactly 1000 accumulated cycles.
        cyc(0, 0, 0, 1);
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 0, 1);
        repeat (999) cyc(0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1, 1);

        // Panic while running, then after run stop.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1);
        cyc(0, 1);
        cyc(0, 1);

        repeat (2500) begin
            cyc($urandom_range(0, 1) == 1,
                ($urandom % 100) < 45,
                ($urandom % 200) == 0,
                ($urandom % 300) == 0,
                ($urandom % 250) == 0,
                ($urandom % 20) == 0);
        end

        // Build up nonzero state, then reset asynchronously mid-burst.
        cyc(0, 0, 0, 1);
        repeat (4) cyc(1, 0);
        repeat (5) cyc(0, 0);
        cyc(0, 0, 1);
        cyc(1, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_u0_held", if0.held_o, 0);
        chk("rst_u0_count", if0.held_count_o, 0);
        chk("rst_u0_dead", if0.dead_o, 0);
        chk("rst_u0_occupancy", if0.occupancy_o, 0);
        chk("rst_u1_turf_err", if1.turf_err_o, 0);
        chk("rst_u1_held", if1.held_o, 0);
        chk("rst_u1_occupancy", if1.occupancy_o, 0);
        @(posedge clk);
        #1;
        do_reset(2);
        cyc(0, 0, 0, 1);
        cyc(1, 0);
        cyc(0, 1);
        cyc(0, 0);
        @(negedge clk);
        #1;

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_snap_left", i), sq[i].size(), 0);
            chk($sformatf("u%0d_trig_left", i), tq[i].size(), 0);
            chk($sformatf("u%0d_release_left", i), rq[i].size(), 0);
            chk($sformatf("u%0d_occ_left", i), oq[i].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
